// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the IF/MEM requesters, the arbiter and the shared memory bus.
// master = arbiter view, slave = requesters/memory view.
interface mem_bus_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        MIO_ready;
    logic        stall;
    logic        bus_err;

    modport master (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, bus_rdata, MIO_ready,
        output if_rdata, if_ack, mem_rdata, mem_ack, bus_req, bus_we, bus_addr, bus_wdata,
               stall, bus_err
    );

    modport slave (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, bus_rdata, MIO_ready,
        input  if_rdata, if_ack, mem_rdata, mem_ack, bus_req, bus_we, bus_addr, bus_wdata,
               stall, bus_err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between instruction fetch and the MEM stage.
// Define ARB_TIMEOUT_EN to abort grants after TIMEOUT_CYCLES without MIO_ready (sets sticky bus_err).
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_bus_arbiter_if.master bus_if
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_MEM = 2'd1,
        GRANT_IF  = 2'd2
    } state_e;

    localparam logic LG_MEM = 1'b0;
    localparam logic LG_IF  = 1'b1;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_ack_q, if_ack_d;
    logic        mem_ack_q, mem_ack_d;
    logic        timeout_s;
    logic [31:0] rdata_in_s;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 32'd1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 32'd1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             bus_err_q, bus_err_d;

    // Abort fires on the edge where the wait count reaches TIMEOUT_CYCLES.
    assign timeout_s = (state_q != IDLE) && !bus_if.MIO_ready && (tmo_cnt_q == TMO_LAST);
    assign bus_if.bus_err = bus_err_q;
`else
    logic [31:0] cfg_unused_s;

    assign cfg_unused_s   = 32'(TIMEOUT_CYCLES);
    assign timeout_s      = 1'b0;
    assign bus_if.bus_err = 1'b0;
`endif

    assign rdata_in_s = timeout_s ? 32'hDEADBEEF : bus_if.bus_rdata;

    // Next-state and next-output computation for the arbiter FSM.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        if_ack_d     = 1'b0;
        mem_ack_d    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        bus_err_d    = bus_err_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef ARB_TIMEOUT_EN
                tmo_cnt_d = {TMO_W{1'b0}};
`endif
                // MEM wins a tie only when IF was served last.
                if (bus_if.mem_req && (!bus_if.if_req || (last_grant_q == LG_IF))) begin
                    state_d     = GRANT_MEM;
                    bus_req_d   = 1'b1;
                    bus_we_d    = bus_if.mem_we;
                    bus_addr_d  = bus_if.mem_addr;
                    bus_wdata_d = bus_if.mem_wdata;
                end else if (bus_if.if_req) begin
                    state_d     = GRANT_IF;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = bus_if.if_addr;
                    bus_wdata_d = 32'h0000_0000;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT_MEM, GRANT_IF: begin
                if (bus_if.MIO_ready || timeout_s) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    if (state_q == GRANT_MEM) begin
                        mem_ack_d    = 1'b1;
                        last_grant_d = LG_MEM;
                        if (!bus_we_q) begin
                            mem_rdata_d = rdata_in_s;
                        end else begin
                            mem_rdata_d = mem_rdata_q;
                        end
                    end else begin
                        if_ack_d     = 1'b1;
                        last_grant_d = LG_IF;
                        if_rdata_d   = rdata_in_s;
                    end
                end else begin
                    state_d = state_q;
                end
`ifdef ARB_TIMEOUT_EN
                if (!bus_if.MIO_ready) begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end else begin
                    tmo_cnt_d = tmo_cnt_q;
                end
                bus_err_d = bus_err_q | timeout_s;
`endif
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= LG_IF;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'h0000_0000;
            bus_wdata_q  <= 32'h0000_0000;
            if_rdata_q   <= 32'h0000_0000;
            mem_rdata_q  <= 32'h0000_0000;
            if_ack_q     <= 1'b0;
            mem_ack_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q    <= {TMO_W{1'b0}};
            bus_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            if_ack_q     <= if_ack_d;
            mem_ack_q    <= mem_ack_d;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            bus_err_q    <= bus_err_d;
`endif
        end
    end

    assign bus_if.bus_req   = bus_req_q;
    assign bus_if.bus_we    = bus_we_q;
    assign bus_if.bus_addr  = bus_addr_q;
    assign bus_if.bus_wdata = bus_wdata_q;
    assign bus_if.if_rdata  = if_rdata_q;
    assign bus_if.mem_rdata = mem_rdata_q;
    assign bus_if.if_ack    = if_ack_q;
    assign bus_if.mem_ack   = mem_ack_q;
    assign bus_if.stall     = (bus_if.if_req & ~if_ack_q) | (bus_if.mem_req & ~mem_ack_q);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; inputs driven and outputs sampled on the falling edge.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if bus_if ();

    mem_bus_arbiter #(.TIMEOUT_CYCLES(32'd8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_if(bus_if)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus_if.if_req    = 1'b0;
        bus_if.if_addr   = 32'h0;
        bus_if.mem_req   = 1'b0;
        bus_if.mem_we    = 1'b0;
        bus_if.mem_addr  = 32'h0;
        bus_if.mem_wdata = 32'h0;
        bus_if.bus_rdata = 32'h0;
        bus_if.MIO_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [31:0] rr_addr [4];
    logic        rr_mem  [4];

    initial begin
        clear_inputs();
        do_reset();

        // Reset state
        check_eq("rst_bus_req",   32'(bus_if.bus_req),   32'd0);
        check_eq("rst_if_ack",    32'(bus_if.if_ack),    32'd0);
        check_eq("rst_mem_ack",   32'(bus_if.mem_ack),   32'd0);
        check_eq("rst_if_rdata",  bus_if.if_rdata,       32'h0);
        check_eq("rst_mem_rdata", bus_if.mem_rdata,      32'h0);
        check_eq("rst_bus_err",   32'(bus_if.bus_err),   32'd0);
        check_eq("rst_stall",     32'(bus_if.stall),     32'd0);

        // IF read, minimum latency
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h0000_0100;
        #1 check_eq("if_stall_req", 32'(bus_if.stall), 32'd1);
        step();
        check_eq("if_bus_req",  32'(bus_if.bus_req), 32'd1);
        check_eq("if_bus_addr", bus_if.bus_addr,     32'h0000_0100);
        check_eq("if_bus_we",   32'(bus_if.bus_we),  32'd0);
        check_eq("if_ack_early", 32'(bus_if.if_ack), 32'd0);
        bus_if.MIO_ready = 1'b1;
        bus_if.bus_rdata = 32'h2008_0005;
        step();
        check_eq("if_ack",       32'(bus_if.if_ack),  32'd1);
        check_eq("if_rdata",     bus_if.if_rdata,     32'h2008_0005);
        check_eq("if_bus_drop",  32'(bus_if.bus_req), 32'd0);
        check_eq("if_stall_ack", 32'(bus_if.stall),   32'd0);
        clear_inputs();
        step();
        check_eq("if_ack_pulse", 32'(bus_if.if_ack), 32'd0);
        check_eq("if_rdata_hold", bus_if.if_rdata,   32'h2008_0005);

        // Simultaneous requests after reset: MEM store first, then IF
        do_reset();
        bus_if.if_req    = 1'b1;
        bus_if.if_addr   = 32'h0;
        bus_if.mem_req   = 1'b1;
        bus_if.mem_we    = 1'b1;
        bus_if.mem_addr  = 32'h0000_0040;
        bus_if.mem_wdata = 32'h0000_ABCD;
        step();
        check_eq("sim_bus_we",    32'(bus_if.bus_we), 32'd1);
        check_eq("sim_bus_addr",  bus_if.bus_addr,    32'h0000_0040);
        check_eq("sim_bus_wdata", bus_if.bus_wdata,   32'h0000_ABCD);
        check_eq("sim_stall1",    32'(bus_if.stall),  32'd1);
        bus_if.MIO_ready = 1'b1;
        bus_if.bus_rdata = 32'h1111_1111;
        step();
        check_eq("sim_mem_ack",   32'(bus_if.mem_ack), 32'd1);
        check_eq("sim_wr_rdata",  bus_if.mem_rdata,    32'h0);
        check_eq("sim_stall2",    32'(bus_if.stall),   32'd1);
        bus_if.mem_req   = 1'b0;
        bus_if.MIO_ready = 1'b0;
        step();
        check_eq("sim_if_req",    32'(bus_if.bus_req), 32'd1);
        check_eq("sim_if_addr",   bus_if.bus_addr,     32'h0);
        check_eq("sim_if_we",     32'(bus_if.bus_we),  32'd0);
        check_eq("sim_if_wdata",  bus_if.bus_wdata,    32'h0);
        check_eq("sim_stall3",    32'(bus_if.stall),   32'd1);
        bus_if.MIO_ready = 1'b1;
        bus_if.bus_rdata = 32'h2222_2222;
        step();
        check_eq("sim_if_ack",    32'(bus_if.if_ack), 32'd1);
        check_eq("sim_if_rdata",  bus_if.if_rdata,    32'h2222_2222);
        check_eq("sim_stall4",    32'(bus_if.stall),  32'd0);
        clear_inputs();
        step();

        // Round-robin with both requesters held (IF was served last)
        rr_addr[0] = 32'h0000_0200; rr_mem[0] = 1'b1;
        rr_addr[1] = 32'h0000_0300; rr_mem[1] = 1'b0;
        rr_addr[2] = 32'h0000_0200; rr_mem[2] = 1'b1;
        rr_addr[3] = 32'h0000_0300; rr_mem[3] = 1'b0;
        bus_if.if_req   = 1'b1;
        bus_if.if_addr  = 32'h0000_0300;
        bus_if.mem_req  = 1'b1;
        bus_if.mem_we   = 1'b0;
        bus_if.mem_addr = 32'h0000_0200;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq($sformatf("rr_addr%0d", i), bus_if.bus_addr, rr_addr[i]);
            bus_if.MIO_ready = 1'b1;
            bus_if.bus_rdata = 32'h0000_A000 + 32'(i);
            step();
            bus_if.MIO_ready = 1'b0;
            if (rr_mem[i]) begin
                check_eq($sformatf("rr_mem_ack%0d", i), 32'(bus_if.mem_ack), 32'd1);
                check_eq($sformatf("rr_mem_rd%0d", i),  bus_if.mem_rdata, 32'h0000_A000 + 32'(i));
            end else begin
                check_eq($sformatf("rr_if_ack%0d", i), 32'(bus_if.if_ack), 32'd1);
                check_eq($sformatf("rr_if_rd%0d", i),  bus_if.if_rdata, 32'h0000_A000 + 32'(i));
            end
        end
        clear_inputs();
        step();

        // Load with MIO_ready low for 5 grant cycles
        bus_if.mem_req  = 1'b1;
        bus_if.mem_we   = 1'b0;
        bus_if.mem_addr = 32'h0000_0080;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq($sformatf("wait_bus_req%0d", i), 32'(bus_if.bus_req), 32'd1);
            check_eq($sformatf("wait_stall%0d", i),   32'(bus_if.stall),   32'd1);
            check_eq($sformatf("wait_ack%0d", i),     32'(bus_if.mem_ack), 32'd0);
        end
        bus_if.MIO_ready = 1'b1;
        bus_if.bus_rdata = 32'hCAFE_F00D;
        step();
        check_eq("wait_mem_ack",   32'(bus_if.mem_ack), 32'd1);
        check_eq("wait_mem_rdata", bus_if.mem_rdata,    32'hCAFE_F00D);
        check_eq("wait_bus_drop",  32'(bus_if.bus_req), 32'd0);
        clear_inputs();
        step();
        check_eq("wait_ack_pulse", 32'(bus_if.mem_ack), 32'd0);

        // Asynchronous reset during GRANT_IF
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h0000_0500;
        step();
        check_eq("rmg_granted", 32'(bus_if.bus_req), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_eq("rmg_bus_drop", 32'(bus_if.bus_req), 32'd0);
        check_eq("rmg_no_ack0", 32'(bus_if.if_ack), 32'd0);
        step();
        check_eq("rmg_no_ack1", 32'(bus_if.if_ack), 32'd0);
        rst_n = 1'b1;
        step();
        check_eq("rmg_regrant", 32'(bus_if.bus_req), 32'd1);
        check_eq("rmg_addr",    bus_if.bus_addr,     32'h0000_0500);
        bus_if.MIO_ready = 1'b1;
        bus_if.bus_rdata = 32'h55AA_55AA;
        step();
        check_eq("rmg_if_ack",   32'(bus_if.if_ack), 32'd1);
        check_eq("rmg_if_rdata", bus_if.if_rdata,    32'h55AA_55AA);
        clear_inputs();
        step();

        // MIO_ready held low: timeout abort when enabled, indefinite wait otherwise
        bus_if.mem_req  = 1'b1;
        bus_if.mem_we   = 1'b0;
        bus_if.mem_addr = 32'h0000_0090;
        for (int k = 0; k < 8; k++) begin
            step();
            check_eq($sformatf("tmo_ack_low%0d", k), 32'(bus_if.mem_ack), 32'd0);
            check_eq($sformatf("tmo_req%0d", k),     32'(bus_if.bus_req), 32'd1);
        end
        step();
`ifdef ARB_TIMEOUT_EN
        check_eq("tmo_mem_ack",   32'(bus_if.mem_ack), 32'd1);
        check_eq("tmo_mem_rdata", bus_if.mem_rdata,    32'hDEAD_BEEF);
        check_eq("tmo_bus_err",   32'(bus_if.bus_err), 32'd1);
        check_eq("tmo_bus_drop",  32'(bus_if.bus_req), 32'd0);
        bus_if.mem_req = 1'b0;
        step();
        step();
        check_eq("tmo_err_sticky", 32'(bus_if.bus_err), 32'd1);
        check_eq("tmo_ack_pulse",  32'(bus_if.mem_ack), 32'd0);
`else
        check_eq("notmo_no_ack",  32'(bus_if.mem_ack), 32'd0);
        check_eq("notmo_bus_err", 32'(bus_if.bus_err), 32'd0);
        check_eq("notmo_bus_req", 32'(bus_if.bus_req), 32'd1);
        bus_if.MIO_ready = 1'b1;
        bus_if.bus_rdata = 32'h7777_0001;
        step();
        check_eq("notmo_late_ack", 32'(bus_if.mem_ack), 32'd1);
        check_eq("notmo_rdata",    bus_if.mem_rdata,    32'h7777_0001);
        clear_inputs();
        step();
`endif
        clear_inputs();
        do_reset();
        check_eq("final_bus_err", 32'(bus_if.bus_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
